// File: rtl/eta2_adder_pipe.sv
// ETA-II approximate adder, two-stage valid/ready pipeline with exact-sum error
// flagging and a saturating error counter. Includes the carry_generator it uses.

module carry_generator #(
    parameter int width = 4
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    output logic [width-1:0] carry
);
    logic c;

    // carry[i] is the carry out of bit i with a carry-in of 0 into bit 0
    always_comb begin
        carry = '0;
        c     = 1'b0;
        for (int i = 0; i < width; i++) begin
            carry[i] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c);
            c        = carry[i];
        end
    end
endmodule

module eta2_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [WIDTH-1:0] input1_i,
    input  logic [WIDTH-1:0] input2_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH:0]   sum_o,
    output logic             err_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    input  logic             clr_cnt_i,
    output logic [CNT_W-1:0] err_cnt_o
);
    localparam int N = WIDTH / SEG;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] gen_carry;
    logic [WIDTH-1:0] psum_next;
    logic [N-1:0]     cin_next;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [WIDTH-1:0] s1_psum;
    logic [N-1:0]     s1_cin;
    logic             s1_ctop;

    logic             adv1;
    logic             adv2;
    logic             accept;
    logic [WIDTH:0]   approx;
    logic [WIDTH:0]   exact;
    logic [SEG:0]     seg;
    logic [SEG-1:0]   cs;

    assign adv2       = !out_valid_o | out_ready_i;
    assign adv1       = !s1_valid | adv2;
    assign in_ready_o = rstn_i & adv1;
    assign accept     = in_valid_i & in_ready_o;

    for (genvar k = 0; k < N; k++) begin : g_seg
        carry_generator #(.width(SEG)) u_cg (
            .a     (input1_i[k*SEG +: SEG]),
            .b     (input2_i[k*SEG +: SEG]),
            .carry (gen_carry[k*SEG +: SEG])
        );
    end

    // Each segment's carry-in-0 sum is a^b^(carries shifted up); the segment
    // MSB carry becomes the next segment's carry-in.
    always_comb begin
        psum_next = '0;
        cin_next  = '0;
        cs        = '0;
        for (int k = 0; k < N; k++) begin
            cs = gen_carry[k*SEG +: SEG];
            psum_next[k*SEG +: SEG] = input1_i[k*SEG +: SEG] ^ input2_i[k*SEG +: SEG] ^ (cs << 1);
        end
        for (int k = 1; k < N; k++) begin
            cin_next[k] = gen_carry[k*SEG-1];
        end
    end

    // Top carry: psum+cin overflow and the stored segment carry are exclusive.
    always_comb begin
        approx = '0;
        seg    = '0;
        for (int k = 0; k < N; k++) begin
            seg = {1'b0, s1_psum[k*SEG +: SEG]} + (SEG+1)'(s1_cin[k]);
            approx[k*SEG +: SEG] = seg[SEG-1:0];
        end
        approx[WIDTH] = s1_ctop | seg[SEG];
        exact = {1'b0, s1_a} + {1'b0, s1_b};
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            s1_valid    <= 1'b0;
            s1_a        <= '0;
            s1_b        <= '0;
            s1_psum     <= '0;
            s1_cin      <= '0;
            s1_ctop     <= 1'b0;
            out_valid_o <= 1'b0;
            sum_o       <= '0;
            err_o       <= 1'b0;
            err_cnt_o   <= '0;
        end else begin
            if (adv1) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_a    <= input1_i;
                    s1_b    <= input2_i;
                    s1_psum <= psum_next;
                    s1_cin  <= cin_next;
                    s1_ctop <= gen_carry[WIDTH-1];
                end
            end
            if (adv2) begin
                out_valid_o <= s1_valid;
                if (s1_valid) begin
                    sum_o <= approx;
                    err_o <= (approx != exact);
                end
            end
            if (clr_cnt_i) begin
                err_cnt_o <= '0;
            end else if (out_valid_o && out_ready_i && err_o && err_cnt_o != CNT_MAX) begin
                err_cnt_o <= err_cnt_o + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_eta2_adder_pipe.sv
// Directed bench for eta2_adder_pipe: single ops, streaming with backpressure,
// counter saturation/clear (second instance with a 2-bit counter) and reset.

module tb_eta2_adder_pipe;
    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] input1;
    logic [15:0] input2;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] sum;
    logic        err;
    logic        out_valid;
    logic        out_ready;
    logic        clr_cnt;
    logic [15:0] err_cnt;

    logic        in_ready2;
    logic [16:0] sum2;
    logic        err2;
    logic        out_valid2;
    logic [1:0]  err_cnt2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    eta2_adder_pipe #(.WIDTH(16), .SEG(4), .CNT_W(16)) dut (
        .clk_i(clk), .rstn_i(rstn), .input1_i(input1), .input2_i(input2),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .sum_o(sum), .err_o(err),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .clr_cnt_i(clr_cnt),
        .err_cnt_o(err_cnt)
    );

    eta2_adder_pipe #(.WIDTH(16), .SEG(4), .CNT_W(2)) dut_sat (
        .clk_i(clk), .rstn_i(rstn), .input1_i(input1), .input2_i(input2),
        .in_valid_i(in_valid), .in_ready_o(in_ready2), .sum_o(sum2), .err_o(err2),
        .out_valid_o(out_valid2), .out_ready_i(out_ready), .clr_cnt_i(clr_cnt),
        .err_cnt_o(err_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one operand pair; returns #1 after the edge where the result is valid.
    task automatic send(input logic [15:0] a, input logic [15:0] b);
        @(posedge clk); #1;
        in_valid = 1'b1;
        input1   = a;
        input2   = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    logic [15:0] va [8] = '{16'h1234, 16'h00FF, 16'hFFFF, 16'h0808, 16'h8000, 16'h0001, 16'hF0F0, 16'h000F};
    logic [15:0] vb [8] = '{16'h4321, 16'h0001, 16'h0001, 16'h0808, 16'h8000, 16'h0002, 16'h0F0F, 16'h0001};
    logic [16:0] vs [8] = '{17'h05555, 17'h00000, 17'h0FF00, 17'h01010, 17'h10000, 17'h00003, 17'h0FFFF, 17'h00010};
    logic        ve [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pat;
        int tx, rx, occ;
        logic acc, hs;

        rstn = 1'b0; in_valid = 1'b0; input1 = '0; input2 = '0;
        out_ready = 1'b1; clr_cnt = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_sum", {15'b0, sum}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_cnt", {16'b0, err_cnt}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", {31'b0, in_ready}, 32'd1);

        send(16'h1234, 16'h4321);
        chk("op1_valid", {31'b0, out_valid}, 32'd1);
        chk("op1_sum", {15'b0, sum}, 32'h05555);
        chk("op1_err", {31'b0, err}, 32'd0);
        @(posedge clk); #1;
        chk("op1_cnt", {16'b0, err_cnt}, 32'd0);
        chk("op1_drop_valid", {31'b0, out_valid}, 32'd0);

        send(16'h00FF, 16'h0001);
        chk("op2_sum", {15'b0, sum}, 32'h00000);
        chk("op2_err", {31'b0, err}, 32'd1);
        @(posedge clk); #1;
        chk("op2_cnt", {16'b0, err_cnt}, 32'd1);

        send(16'hFFFF, 16'h0001);
        chk("op3_sum", {15'b0, sum}, 32'h0FF00);
        chk("op3_err", {31'b0, err}, 32'd1);
        @(posedge clk); #1;
        chk("op3_cnt", {16'b0, err_cnt}, 32'd2);

        send(16'h0808, 16'h0808);
        chk("op4_sum", {15'b0, sum}, 32'h01010);
        chk("op4_err", {31'b0, err}, 32'd0);
        @(posedge clk); #1;
        chk("op4_cnt", {16'b0, err_cnt}, 32'd2);

        send(16'h8000, 16'h8000);
        chk("op5_sum_cout", {15'b0, sum}, 32'h10000);
        chk("op5_err", {31'b0, err}, 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 3; i++) begin
            send(16'h00FF, 16'h0001);
            @(posedge clk); #1;
        end
        chk("sat_cnt16", {16'b0, err_cnt}, 32'd5);
        chk("sat_cnt2", {30'b0, err_cnt2}, 32'd3);

        send(16'h00FF, 16'h0001);
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        chk("clr_cnt16", {16'b0, err_cnt}, 32'd0);
        chk("clr_cnt2", {30'b0, err_cnt2}, 32'd0);

        pat = 4'b1001;
        tx = 0; rx = 0; occ = 0;
        for (int cyc = 0; cyc < 100 && rx < 8; cyc++) begin
            @(posedge clk); #1;
            out_ready = pat[cyc % 4];
            in_valid  = (tx < 8);
            if (tx < 8) begin
                input1 = va[tx];
                input2 = vb[tx];
            end
            @(negedge clk);
            chk("stream_in_ready", {31'b0, in_ready}, {31'b0, !(occ == 2 && !out_ready)});
            acc = in_valid & in_ready;
            hs  = out_valid & out_ready;
            if (hs) begin
                chk($sformatf("stream_sum%0d", rx), {15'b0, sum}, {15'b0, vs[rx]});
                chk($sformatf("stream_err%0d", rx), {31'b0, err}, {31'b0, ve[rx]});
                rx++;
            end
            if (acc) tx++;
            occ = occ + int'(acc) - int'(hs);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_rx_count", rx, 32'd8);
        chk("stream_tx_count", tx, 32'd8);
        @(negedge clk);
        chk("stream_no_extra", {31'b0, out_valid}, 32'd0);

        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1; input1 = 16'h1111; input2 = 16'h2222;
        @(posedge clk); #1;
        input1 = 16'h3333; input2 = 16'h4444;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mid_valid_before_rst", {31'b0, out_valid}, 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_sum", {15'b0, sum}, 32'd0);
        chk("mid_rst_cnt", {16'b0, err_cnt}, 32'd0);
        rstn = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("mid_rel_in_ready", {31'b0, in_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_no_stale", {31'b0, out_valid}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/eta2_adder_pipe.md
# eta2_adder_pipe

Pipelined error-tolerant type-II (ETA-II) adder that consumes the per-segment carry vectors produced by `carry_generator` instances and produces registered approximate sums. Operands enter through a valid/ready handshake and are split into segments. Each segment's carry-in is taken only from the carry-out of the segment directly below it, computed with carry-in 0. The block also computes the exact sum, flags mismatching results, and keeps a saturating error counter for accuracy characterisation.

## Interface
- `WIDTH`, 16: operand width; must be a multiple of `SEG`.
- `SEG`, 4: segment width; also the `width` passed to each `carry_generator` instance.
- `CNT_W`, 16: error counter width.

- `clk_i` in 1: clock. One clock domain.
- `rstn_i` in 1: reset, synchronous, active-low.
- `input1_i` in WIDTH: operand A.
- `input2_i` in WIDTH: operand B.
- `in_valid_i` in 1: operands valid.
- `in_ready_o` out 1: block can accept operands this cycle.
- `sum_o` out WIDTH+1: approximate sum; bit WIDTH is the approximate carry-out.
- `err_o` out 1: `sum_o` differs from the exact 17-bit A+B.
- `out_valid_o` out 1: `sum_o` and `err_o` are valid.
- `out_ready_i` in 1: consumer accepts the result.
- `clr_cnt_i` in 1: synchronous clear of the error counter.
- `err_cnt_o` out CNT_W: saturating count of accepted erroneous results.

## Operation
- Segment k covers bits [k·SEG+SEG-1 : k·SEG], for k = 0 … N-1, where N = WIDTH/SEG.
- Stage 1, on accept:
  - Registers A and B.
  - Registers the segment carry-in vector `cin`:
    - `cin[0]` = 0.
    - `cin[k]` = MSB of `carry_generator(A_seg(k-1), B_seg(k-1))`, for k ≥ 1.
- Stage 2, on advance:
  - Segment sum s_k = A_k + B_k + `cin[k]`, computed at SEG+1 bits.
  - Lower SEG bits of s_k go to `sum_o` bits of segment k.
  - For k < N-1, the carry-out of s_k is discarded (the ETA-II approximation).
  - The carry-out of s_{N-1} goes to `sum_o[WIDTH]`.
  - The exact sum is A+B at WIDTH+1 bits.
  - `err_o` = (approximate sum != exact sum), registered alongside `sum_o`.
- Error counter:
  - Increments by 1 on each output handshake (`out_valid_o & out_ready_i`) with `err_o` = 1.
  - Holds at 2^CNT_W−1 once saturated.
  - `clr_cnt_i` = 1 forces 0 on the next edge and wins over a simultaneous increment.
- Reset (`rstn_i` = 0 at an edge):
  - All outputs go to 0: `out_valid_o`, `sum_o`, `err_o`, `err_cnt_o`.
  - The internal stage-1 valid and all data registers clear.
  - In-flight operations are dropped and no result is emitted for them.
  - `in_ready_o` is 0 while reset is asserted and 1 on the first cycle after release.

## Timing
- Latency: an operand accepted at edge t produces `out_valid_o` = 1 after edge t+1, i.e. 2 cycles.
- Throughput: 1 result per cycle when `out_ready_i` is held at 1.
- Stage-2 advance condition: `adv2` = !`out_valid_o` | `out_ready_i`.
- Stage-1 advance condition: `adv1` = !`s1_valid` | `adv2`.
- `in_ready_o` = `adv1`, combinational from `out_ready_i` and state; there is no combinational path from `in_valid_i`.
- Accept occurs when `in_valid_i` & `in_ready_o`.
- Stall behaviour: while `out_valid_o` = 1 and `out_ready_i` = 0:
  - `sum_o` and `err_o` hold stable.
  - Stage 1 holds if full.
  - Up to 2 results are buffered in total.
- Bubble behaviour: if stage 1 is empty when stage 2 advances, `out_valid_o` drops to 0 the next cycle.
- Counter timing: `err_cnt_o` updates one edge after the handshake.

## Test plan
- Single op A=0x1234, B=0x4321 → after 2 cycles, `sum_o`=0x05555, `err_o`=0, `err_cnt_o` stays 0.
- A=0x00FF, B=0x0001:
  - `cin` = 4'b0010 (`cin[1]`=1 from segment 0; `cin[2]`=0 because F+0 generates no carry).
  - Result: `sum_o`=0x00000 (exact 0x00100), `err_o`=1, `err_cnt_o`=1 one cycle after the handshake.
- A=0xFFFF, B=0x0001 → `sum_o`=0x0FF00 (exact 0x10000), `err_o`=1.
- A=0x0808, B=0x0808 → `sum_o`=0x01010, `err_o`=0.
- Back-to-back stream with backpressure:
  - Stimulus: 8 operands streamed while `out_ready_i` toggles 1,0,0,1,….
  - Results emerge in order and none are lost or duplicated.
  - `in_ready_o` = 0 only when both stages are full and `out_ready_i` = 0.
- Counter boundaries:
  - With CNT_W=2, drive 5 erroneous results → `err_cnt_o` saturates at 3.
  - Assert `clr_cnt_i` together with an erroneous handshake → `err_cnt_o`=0.
  - Assert `rstn_i`=0 mid-stream → `out_valid_o`=0 after the edge and no stale result appears after release.
